// File: rtl/sram_port_arbiter_pkg.sv
// Shared constants for the sram-like port arbiter: requester IDs, FSM encodings
// and transfer sizes.
package sram_port_arbiter_pkg;

    localparam logic REQ_ID_INST = 1'b0;
    localparam logic REQ_ID_DATA = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_GNT_INST = 2'd1,
        ARB_GNT_DATA = 2'd2
    } arb_state_e;

    localparam logic [1:0] SRAM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] SRAM_SIZE_HALF = 2'd1;
    localparam logic [1:0] SRAM_SIZE_WORD = 2'd2;

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of 1-bit requester IDs for transactions whose address phase
// has been accepted but whose response has not yet returned.
module arb_id_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0] id_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             push_en;
    logic             pop_en;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // full/empty come from the pre-cycle count so a same-cycle push and pop
    // are gated independently and leave the count unchanged
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;
    assign head    = id_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            id_q    <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_en) begin
                id_q[wr_ptr] <= push_id;
                wr_ptr       <= ptr_inc(wr_ptr);
            end
            if (pop_en) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_en, pop_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one sram-like port between instruction fetch and data access; data
// wins arbitration, and responses are steered back in issue order.
//
// state        | meaning
// -------------+-------------------------------------------------------
// ARB_IDLE     | no grant; choose data over inst for the next cycle
// ARB_GNT_INST | inst owns the port until its addr_ok or it drops req
// ARB_GNT_DATA | data owns the port until its addr_ok or it drops req
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int AW          = 32,
    parameter int DW          = 32
) (
    input  logic          clk,
    input  logic          resetn,

    input  logic          inst_req,
    input  logic          inst_wr,
    input  logic [1:0]    inst_size,
    input  logic [3:0]    inst_wstrb,
    input  logic [AW-1:0] inst_addr,
    input  logic [DW-1:0] inst_wdata,
    output logic          inst_addr_ok,
    output logic          inst_data_ok,
    output logic [DW-1:0] inst_rdata,

    input  logic          data_req,
    input  logic          data_wr,
    input  logic [1:0]    data_size,
    input  logic [3:0]    data_wstrb,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    output logic          data_addr_ok,
    output logic          data_data_ok,
    output logic [DW-1:0] data_rdata,

    output logic          mem_req,
    output logic          mem_wr,
    output logic [1:0]    mem_size,
    output logic [3:0]    mem_wstrb,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_addr_ok,
    input  logic          mem_data_ok,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_e state_q;
    logic       gnt_inst;
    logic       gnt_data;
    logic       fire;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_head;
    logic       rsp_valid;

    // gating with resetn keeps the port quiet during the reset cycle itself
    assign gnt_inst = resetn & (state_q == ARB_GNT_INST);
    assign gnt_data = resetn & (state_q == ARB_GNT_DATA);

    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_wstrb = 4'd0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_data) begin
            mem_req   = data_req & ~fifo_full;
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_wstrb = data_wstrb;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end else if (gnt_inst) begin
            mem_req   = inst_req & ~fifo_full;
            mem_wr    = inst_wr;
            mem_size  = inst_size;
            mem_wstrb = inst_wstrb;
            mem_addr  = inst_addr;
            mem_wdata = inst_wdata;
        end
    end

    assign fire         = mem_req & mem_addr_ok;
    assign inst_addr_ok = fire & gnt_inst;
    assign data_addr_ok = fire & gnt_data;

    // a response with nothing outstanding (stray or post-reset) is dropped
    assign rsp_valid    = resetn & mem_data_ok & ~fifo_empty;
    assign inst_data_ok = rsp_valid & (fifo_head == REQ_ID_INST);
    assign data_data_ok = rsp_valid & (fifo_head == REQ_ID_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ARB_IDLE;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (data_req)      state_q <= ARB_GNT_DATA;
                    else if (inst_req) state_q <= ARB_GNT_INST;
                    else               state_q <= ARB_IDLE;
                end
                ARB_GNT_INST: begin
                    if (fire || !inst_req) state_q <= ARB_IDLE;
                end
                ARB_GNT_DATA: begin
                    if (fire || !data_req) state_q <= ARB_IDLE;
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    arb_id_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (fire),
        .push_id (gnt_data ? REQ_ID_DATA : REQ_ID_INST),
        .pop     (rsp_valid),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

endmodule
